// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One read outstanding at a time; master drives req/addr, slave answers.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues single imem reads and presents the
// fetched instruction to IF_ID, with stall hold and branch redirect.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            stall,
    input  logic                            branch_taken,
    input  logic [63:0]                     branch_target,
    instruction_fetch_unit_if.master        imem,
    output logic                            if_valid,
    output logic [63:0]                     IF_ID_PC_Out,
    output logic [31:0]                     IF_ID_instruction
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DELIVER
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] req_pc;
    logic        discard;
    logic [63:0] target;
    logic        unused_tgt;

    assign target      = {branch_target[63:2], 2'b00};
    assign unused_tgt  = ^branch_target[1:0];

    assign imem.imem_req  = (state == REQ);
    assign imem.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= REQ;
            pc                <= RESET_PC;
            req_pc            <= RESET_PC;
            discard           <= 1'b0;
            if_valid          <= 1'b0;
            IF_ID_PC_Out      <= 64'h0;
            IF_ID_instruction <= NOP_INSTR;
        end else begin
            unique case (state)
                REQ: begin
                    if (imem.imem_ready) begin
                        req_pc  <= pc;
                        discard <= branch_taken;
                        state   <= WAIT;
                    end
                    if (branch_taken) begin
                        pc <= target;
                    end
                end
                WAIT: begin
                    if (branch_taken) begin
                        pc      <= target;
                        discard <= 1'b1;
                    end
                    // a redirect in the response cycle makes the data stale too
                    if (imem.imem_rvalid) begin
                        if (discard || branch_taken) begin
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            IF_ID_PC_Out      <= req_pc;
                            IF_ID_instruction <= imem.imem_rdata;
                            if_valid          <= 1'b1;
                            pc                <= req_pc + 64'd4;
                            state             <= DELIVER;
                        end
                    end
                end
                DELIVER: begin
                    if (branch_taken) begin
                        if_valid          <= 1'b0;
                        IF_ID_instruction <= NOP_INSTR;
                        pc                <= target;
                        state             <= REQ;
                    end else if (!stall) begin
                        if_valid          <= 1'b0;
                        IF_ID_instruction <= NOP_INSTR;
                        state             <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-stage producer for the IF_ID pipeline register. Holds the program counter, issues one instruction-memory read at a time over a request/response handshake, and presents each fetched instruction with its PC to IF_ID. Honours stall from hazard logic and redirects on taken branches, discarding any in-flight stale fetch.

## Interface
- RESET_PC, 64'h0, PC loaded on reset
- NOP_INSTR, 32'h00000013, instruction output value when no valid fetch is presented (addi x0,x0,0)

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block
- stall  input  1  downstream hold; while high, the presented instruction is not consumed
- branch_taken  input  1  redirect request, single-cycle pulse
- branch_target  input  64  redirect PC; bits [1:0] are forced to 0
- imem_req  output  1  read request valid
- imem_addr  output  64  read address
- imem_ready  input  1  memory accepts request this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  32  read data
- if_valid  output  1  IF_ID_PC_Out/IF_ID_instruction hold a real fetch
- IF_ID_PC_Out  output  64  PC of presented instruction
- IF_ID_instruction  output  32  presented instruction

## Operation
- State machine: REQ, WAIT, DELIVER. Internal registers: pc, req_pc, discard.
- Reset (reset==0 at edge): state=REQ, pc=RESET_PC, discard=0, if_valid=0, IF_ID_PC_Out=0, IF_ID_instruction=NOP_INSTR.
- imem_req=1 only in REQ. imem_addr=pc in every state. Both are combinational from registers.
- REQ:
  - If imem_ready: req_pc<=pc, go WAIT.
  - If branch_taken: pc<=target. If imem_ready is also high, the accepted request is stale: discard<=1, go WAIT.
- WAIT:
  - branch_taken: pc<=target, discard<=1.
  - imem_rvalid with discard==1, or with branch_taken in the same cycle: drop the data, discard<=0, go REQ.
  - imem_rvalid otherwise: IF_ID_PC_Out<=req_pc, IF_ID_instruction<=imem_rdata, if_valid<=1, pc<=req_pc+4, go DELIVER.
- DELIVER (if_valid==1):
  - Priority 1, branch_taken: if_valid<=0, IF_ID_instruction<=NOP_INSTR, pc<=target, go REQ. The instruction is squashed even if stall==0.
  - Priority 2, stall==0: the instruction is consumed. if_valid<=0, IF_ID_instruction<=NOP_INSTR, go REQ.
  - Priority 3, stall==1: hold all outputs unchanged.
- stall has no effect in REQ or WAIT.
- imem_rvalid outside WAIT is ignored.
- Arithmetic: pc+4 is 64-bit and wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC+4 = 0).
- At most one outstanding memory request.

## Timing
- Minimum fetch period is 3 cycles per instruction (REQ, WAIT, DELIVER), given imem_ready=1 and rvalid one cycle after acceptance.
- Fetched data appears on the outputs the cycle after imem_rvalid.
- A branch_taken pulse takes effect on imem_addr the next cycle.
- The first post-redirect request issues at most one cycle after the stale response (if any) returns.
- Reset overrides everything, including in WAIT. A response arriving after reset lands in REQ and is ignored.
- IF_ID_PC_Out keeps the last delivered PC when if_valid==0. It resets to 0.

## Test plan
- Reset: hold reset=0 for 2 cycles, then release with RESET_PC=0x1000. Expect if_valid=0, IF_ID_instruction=0x00000013, imem_req=1, imem_addr=0x1000.
- Sequential fetch: memory always ready, rvalid one cycle after acceptance, rdata=addr[31:0]^0xA5A5A5A5. Expect PCs 0x1000, 0x1004 and 0x1008 delivered every 3 cycles with matching data.
- Stall: hold stall=1 for 4 cycles during DELIVER of PC 0x1004. Expect outputs frozen and imem_req=0 throughout. Expect the next request at 0x1008 one cycle after stall drops.
- Branch in WAIT: branch_taken with target 0x2002 while 0x1008 is outstanding. Expect the 0x1008 data dropped, if_valid to stay 0, and the next request at 0x2000, delivered as PC 0x2000.
- Branch in DELIVER with stall=1: expect a squash (if_valid 0, NOP output), then a request at the target.
- Wrap and mid-op reset: redirect to 0xFFFF_FFFF_FFFF_FFFC and expect the next PC to be 0. Assert reset=0 in WAIT. Expect the reset state, with a late rvalid producing no if_valid.
